// File: rtl/lifo_stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and helpers for the LIFO stack.
//   stack_op_t   : operation decoded from the {push, pop} request pair
//   decode_op()  : maps push/pop request bits onto stack_op_t
//   STACK_DATA_W : default entry width (matches the data memory width)
//   STACK_DEPTH  : default number of entries
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    // Encoding mirrors {push, pop} so the decode is a straight mapping.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        stack_op_t op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// -----------------------------------------------------------------------------
// lifo_stack_if
// Request/status bundle between the CPU (master) and the stack (slave).
//   push, pop, din, clr_err             : requests from the master
//   dout, count, empty, full,
//   overflow, underflow                 : status returned by the stack
// Clock and reset are not part of the bundle; they stay plain ports.
// -----------------------------------------------------------------------------
interface lifo_stack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clr_err, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/lifo_stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// DEPTH x DATA_W storage for the stack: one synchronous write port and one
// asynchronous read port.
//   clk     : write clock, rising edge
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index (combinational read)
//   rdata_o : read data
// -----------------------------------------------------------------------------
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the count register,
    // so clearing it would only cost a reset network on every bit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
// Parametrised LIFO stack for return addresses and operands.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : lifo_stack_if slave port
//         push/pop/din select NONE, PUSH, POP or REPLACE (push and pop together)
//         dout  = top entry, 0 when empty (combinational)
//         count/empty/full all derive from one count register
//         overflow/underflow are sticky, cleared by clr_err (a new error wins)
// -----------------------------------------------------------------------------
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    lifo_stack_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    stack_op_t         op;
    logic              is_empty, is_full;
    logic [CNT_W-1:0]  top_idx;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ovf_set, udf_set;

    assign op       = decode_op(bus.push, bus.pop);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    // Wraps to all-ones when empty; only consumed when the stack is non-empty.
    assign top_idx  = count_q - CNT_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d   = count_q;
        ram_we    = 1'b0;
        ram_waddr = AW'(count_q);
        ovf_set   = 1'b0;
        udf_set   = 1'b0;

        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    ram_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    udf_set = 1'b1;
                end else begin
                    count_d = top_idx;
                end
            end
            OP_REPLACE: begin
                ram_we = 1'b1;
                if (is_empty) begin
                    // Nothing to replace: behave as a push into slot 0 and flag it.
                    udf_set = 1'b1;
                    count_d = CNT_W'(1);
                end else begin
                    // Overwrite the top in place; legal even when full.
                    ram_waddr = AW'(top_idx);
                end
            end
            default: ;
        endcase

        // Set has priority over clear so an error in the clearing cycle is kept.
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        udf_d = udf_set | (udf_q & ~bus.clr_err);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (bus.din),
        .raddr_i (AW'(top_idx)),
        .rdata_o (ram_rdata)
    );

    assign bus.dout      = is_empty ? '0 : ram_rdata;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
// Self-checking bench for lifo_stack (DATA_W=8, DEPTH=16): a table of
// directed vectors with hand-computed expectations, plus a hand-written
// asynchronous reset sequence.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    lifo_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              push;
        logic              pop;
        logic              clr;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
        logic [CNT_W-1:0]  count;
        logic              empty;
        logic              full;
        logic              ovf;
        logic              udf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic push, input logic pop, input logic clr,
                       input logic [7:0] din, input logic [7:0] dout, input int count,
                       input logic empty, input logic full, input logic ovf, input logic udf);
        vec_t v;
        v.name = name; v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.dout = dout; v.count = CNT_W'(count); v.empty = empty; v.full = full;
        v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input logic [7:0] dout, input int count,
                               input logic empty, input logic full, input logic ovf, input logic udf);
        check({tag, ".dout"},  32'(bus.dout),      32'(dout));
        check({tag, ".count"}, 32'(bus.count),     32'(count));
        check({tag, ".empty"}, 32'(bus.empty),     32'(empty));
        check({tag, ".full"},  32'(bus.full),      32'(full));
        check({tag, ".ovf"},   32'(bus.overflow),  32'(ovf));
        check({tag, ".udf"},   32'(bus.underflow), 32'(udf));
    endtask

    // Drive one request on the falling edge, let the rising edge take it,
    // then check just after that edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.clr_err = v.clr;
        bus.din     = v.din;
        @(posedge clk);
        #1;
        check_state(v.name, v.dout, int'(v.count), v.empty, v.full, v.ovf, v.udf);
    endtask

    task automatic idle_inputs();
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
    endtask

    initial begin
        vec_t v;

        // ---------------- vector table ----------------
        //   name            push pop clr din    dout   cnt emp full ovf udf
        add("push11",        1, 0, 0, 8'h11, 8'h11, 1,  0, 0, 0, 0);
        add("push22",        1, 0, 0, 8'h22, 8'h22, 2,  0, 0, 0, 0);
        add("push33",        1, 0, 0, 8'h33, 8'h33, 3,  0, 0, 0, 0);
        add("idle",          0, 0, 0, 8'hEE, 8'h33, 3,  0, 0, 0, 0);
        add("pop_a",         0, 1, 0, 8'h00, 8'h22, 2,  0, 0, 0, 0);
        add("pop_b",         0, 1, 0, 8'h00, 8'h11, 1,  0, 0, 0, 0);
        add("pop_last",      0, 1, 0, 8'h00, 8'h00, 0,  1, 0, 0, 0);
        add("pop_empty",     0, 1, 0, 8'h00, 8'h00, 0,  1, 0, 0, 1);
        add("repl_empty",    1, 1, 0, 8'h5C, 8'h5C, 1,  0, 0, 0, 1);
        add("pop_5c",        0, 1, 0, 8'h00, 8'h00, 0,  1, 0, 0, 1);
        add("clr_udf",       0, 0, 1, 8'h00, 8'h00, 0,  1, 0, 0, 0);
        add("udf_set_wins",  0, 1, 1, 8'h00, 8'h00, 0,  1, 0, 0, 1);
        add("clr_udf2",      0, 0, 1, 8'h00, 8'h00, 0,  1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            add($sformatf("fill%0d", i), 1, 0, 0, 8'(i), 8'(i), i + 1, 0, (i == DEPTH - 1), 0, 0);
        end
        add("push_full",     1, 0, 0, 8'hAA, 8'h0F, 16, 0, 1, 1, 0);
        add("clr_ovf",       0, 0, 1, 8'h00, 8'h0F, 16, 0, 1, 0, 0);
        add("repl_full",     1, 1, 0, 8'h77, 8'h77, 16, 0, 1, 0, 0);
        add("pop_after_rep", 0, 1, 0, 8'h00, 8'h0E, 15, 0, 0, 0, 0);
        add("push99",        1, 0, 0, 8'h99, 8'h99, 16, 0, 1, 0, 0);
        add("push_full2",    1, 0, 0, 8'hAA, 8'h99, 16, 0, 1, 1, 0);
        add("pop_keep_ovf",  0, 1, 0, 8'h00, 8'h0E, 15, 0, 0, 1, 0);
        add("push88",        1, 0, 0, 8'h88, 8'h88, 16, 0, 1, 1, 0);
        add("ovf_set_wins",  1, 0, 1, 8'hBB, 8'h88, 16, 0, 1, 1, 0);
        add("clr_both",      0, 0, 1, 8'h00, 8'h88, 16, 0, 1, 0, 0);

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1'b0;
        #12;
        check_state("reset", 8'h00, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // ---------------- async reset mid-cycle ----------------
        // Drain to a known 3-entry state first.
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        v = '{name: "ar_p1", push: 1, pop: 0, clr: 0, din: 8'hA1, dout: 8'hA1, count: 1,
              empty: 0, full: 0, ovf: 0, udf: 0};
        step(v);
        v.name = "ar_p2"; v.din = 8'hA2; v.dout = 8'hA2; v.count = 2;
        step(v);
        v.name = "ar_p3"; v.din = 8'hA3; v.dout = 8'hA3; v.count = 3;
        step(v);
        // Leave a push pending and pull reset between edges.
        @(negedge clk);
        bus.push = 1'b1;
        bus.din  = 8'hCC;
        #2;
        rst = 1'b0;
        #1;
        check_state("rst_mid", 8'h00, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_state("rst_held", 8'h00, 0, 1, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        v = '{name: "post_rst", push: 1, pop: 0, clr: 0, din: 8'h42, dout: 8'h42, count: 1,
              empty: 0, full: 0, ovf: 0, udf: 0};
        step(v);

        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
